// File: rtl/seq_det_arbiter.sv
// Round-robin owner selection for one shared serial sequence detector.
// Each new owner gets one detector clear cycle, then up to MAX_BURST step cycles.
module seq_det_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         c_in,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 det_clr,
  output logic                 det_en,
  output logic                 det_c,
  input  logic                 det_y,
  output logic [N-1:0]         y_out
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, CLR, GRANT} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   last_id, last_nx, gnt_id_nx, win;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            any_req, release_g;

  assign any_req   = |req;
  assign release_g = ~req[gnt_id] | (cnt == CW'(MAX_BURST - 1));

  // Walk from farthest to nearest so the nearest requester after last_id wins;
  // k == N lands on last_id itself, giving it lowest priority.
  always_comb begin
    win = last_id;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last_id) + k) % N]) win = IW'((int'(last_id) + k) % N);
    end
  end

  always_comb begin
    state_nx  = state;
    gnt_id_nx = gnt_id;
    last_nx   = last_id;
    cnt_nx    = cnt;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nx  = CLR;
          gnt_id_nx = win;
          last_nx   = win;
        end
      end
      CLR: begin
        state_nx = GRANT;
        cnt_nx   = '0;
      end
      GRANT: begin
        if (release_g) begin
          if (any_req) begin
            state_nx  = CLR;
            gnt_id_nx = win;
            last_nx   = win;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are flopped from the next-state decode so they align with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt_id  <= '0;
      last_id <= IW'(N - 1);
      cnt     <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      det_clr <= 1'b0;
      det_en  <= 1'b0;
    end else begin
      state   <= state_nx;
      gnt_id  <= gnt_id_nx;
      last_id <= last_nx;
      cnt     <= cnt_nx;
      gnt     <= (state_nx != IDLE) ? (N'(1) << gnt_id_nx) : '0;
      busy    <= (state_nx != IDLE);
      det_clr <= (state_nx == CLR);
      det_en  <= (state_nx == GRANT);
    end
  end

  assign det_c = det_en & c_in[gnt_id];

  always_comb begin
    y_out = '0;
    if (det_en) y_out[gnt_id] = det_y;
  end
endmodule

// File: doc/seq_det_arbiter.md
Name: seq_det_arbiter

Overview:
Round-robin scheduler that shares one serial sequence-detector FSM among N requesters. Each requester presents a request and a 1-bit serial stream. The arbiter grants one requester at a time and clears the detector between owners so no state history leaks across requesters. It muxes the owner's bit into the detector and routes the detector output back to the owner. It sits between the N stream sources and the single shared detector instance.

Parameters:
N, 4, number of requesters (2..16)
MAX_BURST, 8, maximum cycles a requester may hold the detector per grant (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  N  per-requester request, level-sensitive
c_in  in  N  per-requester serial bit stream
gnt  out  N  one-hot grant, registered
gnt_id  out  $clog2(N)  index of current owner, registered; valid when busy=1
busy  out  1  high in CLR or GRANT state
det_clr  out  1  synchronous clear to shared detector, registered
det_en  out  1  detector step enable, registered
det_c  out  1  bit to detector = c_in[gnt_id] when det_en=1, else 0 (combinational mux)
det_y  in  1  shared detector output
y_out  out  N  y_out[gnt_id] = det_y when det_en=1; all other bits 0 (combinational)

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low: rst_n=0 immediately forces state=IDLE, gnt=0, gnt_id=0, busy=0, det_clr=0, det_en=0, burst counter=0, and the round-robin pointer last_id=N-1, so index 0 has first priority after reset.
  - Reset mid-grant aborts the grant immediately. No completion cycle.
- States: IDLE, CLR, GRANT.
- Arbitration function:
  - Search req from index (last_id+1) mod N upward, wrapping.
  - The first set bit wins. last_id itself is checked last.
  - Evaluated only on IDLE exit and on GRANT release.
- IDLE:
  - If |req, the next state is CLR.
  - Load winner into gnt_id/gnt. Set last_id=winner. det_clr=1 next cycle.
  - Else remain in IDLE.
- CLR (exactly 1 cycle):
  - det_clr=1, det_en=0. Clear the burst counter.
  - Go to GRANT unconditionally, even if req[gnt_id] has dropped. GRANT then releases on its first cycle.
- GRANT:
  - det_en=1, det_clr=0. Counter increments each cycle.
  - Release occurs when req[gnt_id]=0 is sampled, or when the counter reaches MAX_BURST-1. GRANT therefore lasts at most MAX_BURST cycles.
  - On release with |req (any requester, including the current owner if still requesting): run arbitration, go directly to CLR with the new winner, update gnt_id/last_id. No IDLE bubble.
  - On release with req=0: go to IDLE, gnt=0, busy=0, det_en=0.
- Latency:
  - req rises in IDLE at cycle t: gnt and det_clr assert at t+1; det_en asserts at t+2.
  - Between consecutive owners, exactly one CLR cycle separates their det_en windows.
- The owner's c_in bit is consumed by the detector on each cycle with det_en=1.
- Fairness: a continuously requesting set of requesters is served in strict rotation. No requester waits more than (N-1)*(MAX_BURST+1) cycles from req assertion to gnt.
- Simultaneous events: a req change on the current owner in the same cycle as counter expiry is treated as a single release; both conditions are handled identically.
- Burst counter width: $clog2(MAX_BURST+1) bits. No wrap is possible because it is cleared in CLR.
- gnt is always one-hot or zero. gnt, gnt_id, and busy are mutually consistent every cycle.

Test Plan:
- Reset: assert rst_n=0 mid-GRANT with req=4'b1111 -> same cycle gnt=0, det_en=0, busy=0. After release, req=4'b1111 -> first gnt=4'b0001.
- Single requester: req=4'b0100 held 3 cycles then dropped -> gnt=4'b0100 at t+1, det_clr pulse at t+1, det_en high for 3 cycles, then IDLE. det_c tracks c_in[2].
- Burst limit: req=4'b0010 held 20 cycles -> GRANT windows of 8 cycles each, separated by 1-cycle CLR, gnt stays 4'b0010.
- Rotation: req=4'b1111 continuous -> gnt order 0001, 0010, 0100, 1000, 0001. Each owner gets 8 det_en cycles. Never two owners without a det_clr between them.
- Routing: owner id 3 with det_y=1 -> y_out=4'b1000; det_y=1 during CLR -> y_out=0. det_c=0 when det_en=0 regardless of c_in.
- Drop during CLR: req[1] falls on the CLR cycle with req[3]=1 -> one GRANT cycle for id 1, then CLR and grant to id 3.
